// File: rtl/conv_deinterleaver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : conv_deinterleaver
// Purpose  : Forney convolutional deinterleaver; per-branch circular delay
//            lines packed into one RAM, with priming and resync handling.
// Revision : 1.0 - initial release
// ============================================================================
module conv_deinterleaver #(
    parameter int BRANCHES = 12,
    parameter int UNIT     = 17,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_sync,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    output logic             out_sync,
    output logic [WIDTH-1:0] dout,
    output logic             sync_err
);

    localparam int c_DMAX  = (BRANCHES - 1) * UNIT;
    localparam int c_TOTAL = (UNIT * BRANCHES * (BRANCHES - 1)) / 2;
    localparam int c_PRIME = BRANCHES * (BRANCHES - 1) * UNIT;
    localparam int c_IW    = (BRANCHES > 1) ? $clog2(BRANCHES) : 1;
    localparam int c_PW    = (c_DMAX > 1) ? $clog2(c_DMAX) : 1;
    localparam int c_AW    = (c_TOTAL > 1) ? $clog2(c_TOTAL) : 1;
    localparam int c_CW    = $clog2(c_PRIME + 1);

    function automatic int branch_depth(input int b);
        return (BRANCHES - 1 - b) * UNIT;
    endfunction

    // Start of branch b's region: sum of the depths of all lower branches.
    function automatic int branch_base(input int b);
        return UNIT * (b * (BRANCHES - 1) - (b * (b - 1)) / 2);
    endfunction

    logic [c_IW-1:0]  idx_q, idx_d;
    logic [c_PW-1:0]  ptr_q [BRANCHES];
    logic [c_PW-1:0]  ptr_d [BRANCHES];
    logic [c_CW-1:0]  cnt_q, cnt_d;
    logic             primed_q, primed_d;
    logic             valid_q, valid_d;
    logic             osync_q, osync_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic [WIDTH-1:0] mem [c_TOTAL];
    logic [c_IW-1:0]  branch;
    logic [c_PW-1:0]  ptr_cur;
    logic [c_AW-1:0]  addr;
    logic [WIDTH-1:0] rd_data;
    logic             last_br;
    logic             wrap;
    logic             resync;

    // A symbol flagged with in_sync is always branch 0, whatever the index says.
    always_comb begin
        branch  = in_sync ? '0 : idx_q;
        last_br = (int'(branch) == BRANCHES - 1);
        ptr_cur = ptr_q[branch];
        wrap    = (int'(ptr_cur) == branch_depth(int'(branch)) - 1);
        addr    = last_br ? '0 : c_AW'(branch_base(int'(branch)) + int'(ptr_cur));
        resync  = in_valid && in_sync && (idx_q != '0);
    end

    assign rd_data = mem[addr];

    always_comb begin
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        primed_d = primed_q;
        valid_d  = 1'b0;
        osync_d  = 1'b0;
        err_d    = 1'b0;
        dout_d   = dout_q;
        if (in_valid) begin
            idx_d   = last_br ? '0 : branch + c_IW'(1);
            dout_d  = last_br ? din : rd_data;
            valid_d = primed_q;
            osync_d = (branch == '0);
            err_d   = resync;
            if (!last_br) begin
                ptr_d[branch] = wrap ? '0 : ptr_cur + c_PW'(1);
            end
            // Resync restarts priming; pointers stay so the RAM stays consistent.
            if (resync) begin
                cnt_d    = '0;
                primed_d = 1'b0;
            end else if (!primed_q) begin
                cnt_d    = cnt_q + c_CW'(1);
                primed_d = (cnt_q == c_CW'(c_PRIME - 1));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q    <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
            valid_q  <= 1'b0;
            osync_q  <= 1'b0;
            err_q    <= 1'b0;
            dout_q   <= '0;
            for (int b = 0; b < BRANCHES; b++) begin
                ptr_q[b] <= '0;
            end
        end else begin
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            valid_q  <= valid_d;
            osync_q  <= osync_d;
            err_q    <= err_d;
            dout_q   <= dout_d;
            for (int b = 0; b < BRANCHES; b++) begin
                ptr_q[b] <= ptr_d[b];
            end
        end
    end

    // Symbol storage carries no reset; read-before-write gives the oldest entry.
    always_ff @(posedge clk) begin
        if (in_valid && !last_br) begin
            mem[addr] <= din;
        end
    end

    assign out_valid = valid_q;
    assign out_sync  = osync_q;
    assign dout      = dout_q;
    assign sync_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_deinterleaver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_conv_deinterleaver
// Purpose  : Drives a small (3,2) and a default (12,17) deinterleaver from
//            interleaver models and checks them against queue-based models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_deinterleaver;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] in_sync  = 2'b00;
    logic [7:0] din [2];
    logic [1:0] ov, os, se;
    logic [7:0] dout_w [2];

    always #5 clk = ~clk;

    conv_deinterleaver #(.BRANCHES(3), .UNIT(2), .WIDTH(8)) u_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sync(in_sync[0]),
        .din(din[0]), .out_valid(ov[0]), .out_sync(os[0]), .dout(dout_w[0]),
        .sync_err(se[0])
    );

    conv_deinterleaver #(.BRANCHES(12), .UNIT(17), .WIDTH(8)) u_big (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sync(in_sync[1]),
        .din(din[1]), .out_valid(ov[1]), .out_sync(os[1]), .dout(dout_w[1]),
        .sync_err(se[1])
    );

    int nb [2];
    int un [2];
    int pp [2];
    int idx [2];
    int cnt [2];
    int acc [2];
    int ii [2];
    int srcn [2];
    int err_cnt [2];
    bit primed [2];
    bit first_seen [2];
    bit e2e [2];
    bit inj [2];
    bit src_rand;

    logic [8:0] dq [2][12][$];
    logic [7:0] iq [2][12][$];
    logic [7:0] srcq [2][$];

    bit         ev [2];
    bit         es [2];
    bit         ee [2];
    bit         ek [2];
    logic [7:0] ed [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dep(input int i, input int b);
        return (nb[i] - 1 - b) * un[i];
    endfunction

    function automatic string nm(input int i);
        return (i == 0) ? "small" : "big";
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            idx[i] = 0; cnt[i] = 0; primed[i] = 0; acc[i] = 0; ii[i] = 0; srcn[i] = 0;
            first_seen[i] = 0; e2e[i] = 1; inj[i] = 0;
            ev[i] = 0; es[i] = 0; ee[i] = 0; ek[i] = 1; ed[i] = 8'h00;
            srcq[i].delete();
            for (int b = 0; b < nb[i]; b++) begin
                dq[i][b].delete();
                iq[i][b].delete();
                repeat (dep(i, b)) dq[i][b].push_back(9'h000);
                repeat (b * un[i]) iq[i][b].push_back(8'h00);
            end
        end
    endtask

    // Interleave one source byte, drive it, and predict the deinterleaver's response.
    task automatic step(input int i);
        logic [7:0] s, o;
        logic [8:0] r;
        int ib, b;
        bit sy;
        s  = src_rand ? 8'($urandom) : 8'(srcn[i]);
        srcn[i]++;
        ib = ii[i];
        if (inj[i] && idx[i] == 2) begin
            ib = 0; inj[i] = 0; e2e[i] = 0;
        end
        if (ib == 0) o = s;
        else begin
            o = iq[i][ib].pop_front();
            iq[i][ib].push_back(s);
        end
        sy    = (ib == 0);
        ii[i] = (ib + 1) % nb[i];
        srcq[i].push_back(s);
        din[i]     = o;
        in_sync[i] = sy;

        b = sy ? 0 : idx[i];
        if (dep(i, b) == 0) r = {1'b1, o};
        else begin
            r = dq[i][b].pop_front();
            dq[i][b].push_back({1'b1, o});
        end
        ev[i] = primed[i];
        es[i] = (b == 0);
        ee[i] = sy && (idx[i] != 0);
        ek[i] = r[8];
        ed[i] = r[7:0];
        if (ee[i]) begin
            cnt[i] = 0; primed[i] = 0;
        end else if (!primed[i]) begin
            cnt[i]++;
            if (cnt[i] == pp[i]) primed[i] = 1;
        end
        idx[i] = (b + 1) % nb[i];
        acc[i]++;
    endtask

    task automatic check_outputs();
        logic [7:0] want;
        for (int i = 0; i < 2; i++) begin
            chk({nm(i), ".out_valid"}, 32'(ov[i]), 32'(ev[i]));
            chk({nm(i), ".out_sync"}, 32'(os[i]), 32'(es[i]));
            chk({nm(i), ".sync_err"}, 32'(se[i]), 32'(ee[i]));
            if (ek[i]) chk({nm(i), ".dout"}, 32'(dout_w[i]), 32'(ed[i]));
            if (ov[i] === 1'b1 && !first_seen[i]) begin
                first_seen[i] = 1;
                chk({nm(i), ".first_valid_at"}, 32'(acc[i]), 32'(pp[i] + 1));
            end
            if (ev[i] && e2e[i]) begin
                if (srcq[i].size() == 0) chk({nm(i), ".e2e_underflow"}, 32'd0, 32'd1);
                else begin
                    want = srcq[i].pop_front();
                    chk({nm(i), ".e2e_dout"}, 32'(dout_w[i]), 32'(want));
                end
            end
            if (se[i] === 1'b1) err_cnt[i]++;
        end
    endtask

    task automatic cycle(input bit v);
        @(posedge clk);
        #1;
        check_outputs();
        if (v) begin
            in_valid = 1'b1;
            for (int i = 0; i < 2; i++) step(i);
        end else begin
            in_valid = 1'b0;
            in_sync  = 2'b00;
            for (int i = 0; i < 2; i++) begin
                ev[i] = 0; es[i] = 0; ee[i] = 0;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({nm(i), tag, ".out_valid"}, 32'(ov[i]), 32'd0);
            chk({nm(i), tag, ".out_sync"}, 32'(os[i]), 32'd0);
            chk({nm(i), tag, ".sync_err"}, 32'(se[i]), 32'd0);
            chk({nm(i), tag, ".dout"}, 32'(dout_w[i]), 32'd0);
        end
    endtask

    // Reset is raised mid-cycle so its effect can be seen before the next clock edge.
    task automatic do_reset(input bit async_chk);
        @(posedge clk);
        #1;
        check_outputs();
        in_valid = 1'b0;
        in_sync  = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        #1;
        if (async_chk) chk_zero(".async");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int guard;
        nb[0] = 3;  un[0] = 2;
        nb[1] = 12; un[1] = 17;
        for (int i = 0; i < 2; i++) begin
            pp[i]  = nb[i] * (nb[i] - 1) * un[i];
            din[i] = 8'h00;
            err_cnt[i] = 0;
        end
        src_rand = 0;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        chk_zero(".reset");
        @(negedge clk);
        reset = 1'b0;

        // Continuous counting stream
        repeat (64) cycle(1'b1);

        // Same stream with random gaps
        do_reset(1'b0);
        guard = 0;
        while (acc[0] < 64 && guard < 1000) begin
            cycle($urandom_range(0, 99) >= 30);
            guard++;
        end
        chk("small.gap_stream_accepted", 32'(acc[0]), 32'd64);

        // Forced resync at branch index 2
        err_cnt[0] = 0;
        err_cnt[1] = 0;
        inj[0] = 1;
        inj[1] = 1;
        repeat (60) cycle($urandom_range(0, 99) >= 30);
        chk("small.resync_pulses", 32'(err_cnt[0]), 32'd1);
        chk("big.resync_pulses", 32'(err_cnt[1]), 32'd1);

        // Asynchronous reset after 40 symbols, then restart
        do_reset(1'b0);
        repeat (40) cycle(1'b1);
        do_reset(1'b1);
        repeat (64) cycle(1'b1);

        // Default-parameter random run
        do_reset(1'b0);
        src_rand = 1;
        repeat (5000) cycle(1'b1);
        @(posedge clk);
        #1;
        check_outputs();
        chk("big.first_valid_seen", 32'(first_seen[1]), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
